// File: rtl/s2_pipe.sv
// s2_pipe - four-way registered select feeding a DEPTH-stage elastic pipeline.
//
// The selected word RM = D[{S1,S0}] with S1 = A1|B1 and S0 = A0&B0 is
// accepted on in_valid & in_ready and travels through DEPTH valid/data
// stages. Empty stages always accept, so bubbles collapse even while the
// consumer stalls. in_ready is combinational from out_ready through the
// valid chain (no skid buffer).
//
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset (clears valids, data, occ)
//   sclr       synchronous flush, same clear as reset, wins over input
//   D0..D3     N-bit data inputs
//   A1,B1      S1 = A1|B1
//   A0,B0      S0 = A0&B0
//   in_valid   upstream word valid
//   in_ready   stage 0 can accept this cycle
//   out_data   last-stage data
//   out_valid  last stage holds valid data
//   out_ready  consumer accepts this cycle
//   occ        registered count of valid stages, 0..DEPTH
module s2_pipe #(
  parameter  int N     = 8,
  parameter  int DEPTH = 2,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          sclr,
  input  logic [N-1:0]  D0,
  input  logic [N-1:0]  D1,
  input  logic [N-1:0]  D2,
  input  logic [N-1:0]  D3,
  input  logic          A1,
  input  logic          B1,
  input  logic          A0,
  input  logic          B0,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] occ
);

  logic [1:0]       w_sel;
  logic [N-1:0]     w_rm;
  logic [DEPTH-1:0] r_v;
  logic [N-1:0]     r_d [DEPTH];
  logic [OW-1:0]    r_occ;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_v_in;
  logic [N-1:0]     w_d_in [DEPTH];
  logic [DEPTH-1:0] w_v_nxt;
  logic [OW-1:0]    w_cnt_nxt;

  assign w_sel = {A1 | B1, A0 & B0};

  // All four codes decode to a data input, so the mux is fully defined.
  always_comb begin
    w_rm = D0;
    case (w_sel)
      2'b00:   w_rm = D0;
      2'b01:   w_rm = D1;
      2'b10:   w_rm = D2;
      default: w_rm = D3;
    endcase
  end

  // Advance chain, evaluated from the output back towards stage 0: a stage
  // may load if it is empty or if the stage after it is moving.
  always_comb begin
    logic acc;
    w_adv = '0;
    acc   = !r_v[DEPTH-1] | out_ready;
    w_adv[DEPTH-1] = acc;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      acc      = !r_v[k] | acc;
      w_adv[k] = acc;
    end
  end

  // Incoming valid/data for each stage.
  always_comb begin
    w_v_in    = '0;
    w_v_in[0] = in_valid;
    w_d_in[0] = w_rm;
    for (int k = 1; k < DEPTH; k++) begin
      w_v_in[k] = r_v[k-1];
      w_d_in[k] = r_d[k-1];
    end
  end

  always_comb begin
    w_v_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_v_nxt[k] = w_adv[k] ? w_v_in[k] : r_v[k];
    end
  end

  // occ tracks the valid bits that will be present after this edge, so the
  // registered count always agrees with the registered valid chain.
  always_comb begin
    w_cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_cnt_nxt = w_cnt_nxt + OW'(w_v_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_v   <= '0;
      r_occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else if (sclr) begin
      r_v   <= '0;
      r_occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      r_occ <= w_cnt_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= w_v_in[k];
          // A bubble only clears the valid bit; data keeps its last value.
          if (w_v_in[k]) begin
            r_d[k] <= w_d_in[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign occ       = r_occ;

endmodule

// File: tb/tb_s2_pipe.sv
// Directed checks on an N=8/DEPTH=2 instance followed by a random soak on an
// N=16/DEPTH=4 instance against a queue scoreboard.
module tb_s2_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Instance a: N=8, DEPTH=2
  logic       a_clr_n, a_sclr, a_in_valid, a_out_ready;
  logic       a_A1, a_B1, a_A0, a_B0;
  logic [7:0] a_D0, a_D1, a_D2, a_D3;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data;
  logic [1:0] a_occ;

  // Instance b: N=16, DEPTH=4
  logic        b_clr_n, b_sclr, b_in_valid, b_out_ready;
  logic        b_A1, b_B1, b_A0, b_B0;
  logic [15:0] b_D0, b_D1, b_D2, b_D3;
  logic        b_in_ready, b_out_valid;
  logic [15:0] b_out_data;
  logic [2:0]  b_occ;

  s2_pipe #(.N(8), .DEPTH(2)) u_a (
    .clk(clk), .clr_n(a_clr_n), .sclr(a_sclr),
    .D0(a_D0), .D1(a_D1), .D2(a_D2), .D3(a_D3),
    .A1(a_A1), .B1(a_B1), .A0(a_A0), .B0(a_B0),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .occ(a_occ)
  );

  s2_pipe #(.N(16), .DEPTH(4)) u_b (
    .clk(clk), .clr_n(b_clr_n), .sclr(b_sclr),
    .D0(b_D0), .D1(b_D1), .D2(b_D2), .D3(b_D3),
    .A1(b_A1), .B1(b_B1), .A0(b_A0), .B0(b_B0),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .occ(b_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setsel(input logic [3:0] abab);
    {a_A1, a_B1, a_A0, a_B0} = abab;
  endtask

  function automatic logic [15:0] model_sel(input logic a1, input logic b1,
                                            input logic a0, input logic b0,
                                            input logic [15:0] d0, input logic [15:0] d1,
                                            input logic [15:0] d2, input logic [15:0] d3);
    logic s1, s0;
    s1 = a1 | b1;
    s0 = a0 & b0;
    if (!s1 && !s0) return d0;
    if (!s1 &&  s0) return d1;
    if ( s1 && !s0) return d2;
    return d3;
  endfunction

  logic [15:0] q[$];
  logic [15:0] expw;

  initial begin
    a_clr_n = 1'b0; a_sclr = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    setsel(4'b0000);
    a_D0 = 8'h11; a_D1 = 8'h22; a_D2 = 8'h33; a_D3 = 8'h44;
    b_clr_n = 1'b0; b_sclr = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    {b_A1, b_B1, b_A0, b_B0} = 4'b0000;
    b_D0 = '0; b_D1 = '0; b_D2 = '0; b_D3 = '0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  32'(a_out_data),  32'd0);
    chk("rst_occ",       32'(a_occ),       32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    a_clr_n = 1'b1; b_clr_n = 1'b1;
    #1;
    chk("rel_out_valid", 32'(a_out_valid), 32'd0);
    tick();

    // Select map, streaming with out_ready=1
    a_out_ready = 1'b1; a_in_valid = 1'b1;
    setsel(4'b0000); tick();
    chk("lat_not_one",  32'(a_out_valid), 32'd0);
    chk("lat_occ1",     32'(a_occ),       32'd1);
    setsel(4'b0011); tick();
    chk("sel_0000",     32'(a_out_data),  32'h11);
    chk("sel_valid",    32'(a_out_valid), 32'd1);
    setsel(4'b0100); tick();
    chk("sel_0011",     32'(a_out_data),  32'h22);
    setsel(4'b1011); tick();
    chk("sel_0100",     32'(a_out_data),  32'h33);
    setsel(4'b0010); tick();
    chk("sel_1011",     32'(a_out_data),  32'h44);
    chk("stream_occ",   32'(a_occ),       32'd2);
    a_in_valid = 1'b0; tick();
    chk("sel_0010",     32'(a_out_data),  32'h11);
    tick();
    chk("drain_valid",  32'(a_out_valid), 32'd0);
    chk("drain_occ",    32'(a_occ),       32'd0);
    tick();
    chk("empty_hold",   32'(a_out_data),  32'h11);

    // Stall / fill
    setsel(4'b0000); a_out_ready = 1'b0; a_in_valid = 1'b1; a_D0 = 8'hA1;
    #1;
    chk("fill_rdy0",    32'(a_in_ready),  32'd1);
    tick();
    chk("fill_occ1",    32'(a_occ),       32'd1);
    chk("fill_rdy1",    32'(a_in_ready),  32'd1);
    a_D0 = 8'hA2; tick();
    chk("fill_occ2",    32'(a_occ),       32'd2);
    chk("fill_rdy2",    32'(a_in_ready),  32'd0);
    chk("fill_head",    32'(a_out_data),  32'hA1);
    a_D0 = 8'hA3; setsel(4'b1011); tick();
    chk("stall_occ",    32'(a_occ),       32'd2);
    chk("stall_head",   32'(a_out_data),  32'hA1);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1;
    chk("unstall_rdy",  32'(a_in_ready),  32'd1);
    tick();
    chk("unstall_w2",   32'(a_out_data),  32'hA2);
    chk("unstall_occ",  32'(a_occ),       32'd1);
    tick();
    chk("no_dup_valid", 32'(a_out_valid), 32'd0);
    chk("no_dup_occ",   32'(a_occ),       32'd0);

    // Bubble collapse
    setsel(4'b0000); a_out_ready = 1'b0; a_in_valid = 1'b1; a_D0 = 8'hC1;
    tick();
    chk("bub_occ_a",    32'(a_occ),       32'd1);
    chk("bub_valid_a",  32'(a_out_valid), 32'd0);
    a_in_valid = 1'b0; tick();
    chk("bub_valid_b",  32'(a_out_valid), 32'd1);
    chk("bub_data_b",   32'(a_out_data),  32'hC1);
    tick(); tick();
    chk("bub_occ_c",    32'(a_occ),       32'd1);
    chk("bub_rdy_c",    32'(a_in_ready),  32'd1);
    a_in_valid = 1'b1; a_D0 = 8'hC2; tick();
    chk("bub_occ_d",    32'(a_occ),       32'd2);
    chk("bub_rdy_d",    32'(a_in_ready),  32'd0);

    // Full with out_ready=1: retire and accept in the same cycle
    a_out_ready = 1'b1; a_D0 = 8'hC3;
    #1;
    chk("full_rdy",     32'(a_in_ready),  32'd1);
    tick();
    chk("full_occ",     32'(a_occ),       32'd2);
    chk("full_data",    32'(a_out_data),  32'hC2);

    // Flush with a concurrent transfer
    a_D0 = 8'hC4; a_sclr = 1'b1;
    #1;
    chk("flush_rdy",    32'(a_in_ready),  32'd1);
    tick();
    a_sclr = 1'b0; a_in_valid = 1'b0;
    chk("flush_occ",    32'(a_occ),       32'd0);
    chk("flush_valid",  32'(a_out_valid), 32'd0);
    chk("flush_data",   32'(a_out_data),  32'd0);
    tick(); tick();
    chk("flush_absent", 32'(a_out_valid), 32'd0);
    chk("flush_occ2",   32'(a_occ),       32'd0);

    // Reset mid-stream
    a_in_valid = 1'b1; a_D0 = 8'hE1; tick();
    a_D0 = 8'hE2; tick();
    chk("mid_occ",      32'(a_occ),       32'd2);
    a_clr_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_occ",   32'(a_occ),       32'd0);
    chk("mid_rst_rdy",   32'(a_in_ready),  32'd1);
    chk("mid_rst_data",  32'(a_out_data),  32'd0);
    tick(); tick();
    chk("mid_hold_occ",  32'(a_occ),       32'd0);
    chk("mid_hold_valid", 32'(a_out_valid), 32'd0);
    a_D0 = 8'hE3; a_clr_n = 1'b1;
    #1;
    chk("rel_glitch",   32'(a_out_valid), 32'd0);
    tick();
    chk("rel_lat1",     32'(a_out_valid), 32'd0);
    chk("rel_occ1",     32'(a_occ),       32'd1);
    tick();
    chk("rel_lat2",     32'(a_out_valid), 32'd1);
    chk("rel_data",     32'(a_out_data),  32'hE3);
    a_in_valid = 1'b0;

    // Random soak on the DEPTH=4 instance
    for (int cyc = 0; cyc < 10000; cyc++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_A1 = 1'($urandom_range(0, 1));
      b_B1 = 1'($urandom_range(0, 1));
      b_A0 = 1'($urandom_range(0, 1));
      b_B0 = 1'($urandom_range(0, 1));
      b_D0 = 16'($urandom);
      b_D1 = 16'($urandom);
      b_D2 = 16'($urandom);
      b_D3 = 16'($urandom);
      #1;
      chk("soak_occ", 32'(b_occ), 32'(q.size()));
      if (b_out_valid && b_out_ready && q.size() > 0) begin
        expw = q.pop_front();
        chk("soak_data", 32'(b_out_data), 32'(expw));
      end
      if (b_in_valid && b_in_ready) begin
        q.push_back(model_sel(b_A1, b_B1, b_A0, b_B0, b_D0, b_D1, b_D2, b_D3));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
